// File: rtl/pad_arb_pkg.sv
// Shared types and constants for the pad ownership arbiter.
package pad_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GPIO   = 2'd1,
    PERIPH = 2'd2,
    TURN   = 2'd3
  } pad_state_e;

  // Turnaround counter width; covers TA_CYCLES up to 15.
  localparam int TA_CNT_W = 4;

  localparam logic OWNER_GPIO   = 1'b0;
  localparam logic OWNER_PERIPH = 1'b1;

  // Owner selection for a pad that nothing is driving: the peripheral
  // wins over GPIO, otherwise the pad stays released.
  function automatic pad_state_e idle_rule(input logic req, input logic gpio_oe);
    if (req) begin
      return PERIPH;
    end
    if (gpio_oe) begin
      return GPIO;
    end
    return IDLE;
  endfunction

endpackage

// File: rtl/pad_arb_cell.sv
// One pad's ownership FSM, turnaround counter and registered pad drivers.
//
// state  | meaning
// IDLE   | nobody drives the pad, oeb=1
// GPIO   | GPIO block owns the pad
// PERIPH | alternate-function peripheral owns the pad
// TURN   | handover in progress, pad tri-stated for TA_CYCLES cycles
//
// TA_CYCLES must be in 1..15.
module pad_arb_cell
  import pad_arb_pkg::*;
#(
  parameter int TA_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req,
  input  logic periph_out,
  input  logic gpio_oe,
  input  logic gpio_out,
  output logic pad_out,
  output logic pad_oeb,
  output logic owner,
  output logic busy
);

  localparam logic [TA_CNT_W-1:0] TA_LOAD = TA_CNT_W'(TA_CYCLES - 1);

  pad_state_e            state_q, state_d;
  logic                  tgt_q, tgt_d;
  logic [TA_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  out_q, out_d;
  logic                  oeb_q, oeb_d;

  // State, turnaround bookkeeping and pad drivers, all reset asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tgt_q   <= OWNER_GPIO;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      oeb_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
    end
  end

  // Next-state: owner changes always pass through TURN, which runs to completion.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = idle_rule(req, gpio_oe);
      end
      GPIO: begin
        if (req) begin
          state_d = TURN;
          tgt_d   = OWNER_PERIPH;
          cnt_d   = TA_LOAD;
        end else if (!gpio_oe) begin
          state_d = IDLE;
        end
      end
      PERIPH: begin
        if (!req) begin
          if (gpio_oe) begin
            state_d = TURN;
            tgt_d   = OWNER_GPIO;
            cnt_d   = TA_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        // Re-evaluate requests at expiry so a dropped request never lands
        // the pad in a stale owner.
        if (cnt_q == '0) begin
          state_d = idle_rule(req, gpio_oe);
        end else begin
          cnt_d = cnt_q - TA_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pad drive values derived from the next state, giving one cycle of latency.
  always_comb begin
    out_d = 1'b0;
    oeb_d = 1'b1;
    case (state_d)
      GPIO: begin
        oeb_d = ~gpio_oe;
        out_d = gpio_out;
      end
      PERIPH: begin
        oeb_d = 1'b0;
        out_d = periph_out;
      end
      default: begin
        out_d = 1'b0;
        oeb_d = 1'b1;
      end
    endcase
  end

  assign pad_out = out_q;
  assign pad_oeb = oeb_q;
  assign owner   = (state_q == PERIPH);
  assign busy    = (state_q == TURN);

  // A turnaround always heads towards the owner opposite the one it left.
  tgt_to_periph_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == GPIO && state_d == TURN) |=> (tgt_q == OWNER_PERIPH));
  tgt_to_gpio_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == PERIPH && state_d == TURN) |=> (tgt_q == OWNER_GPIO));

endmodule

// File: rtl/pad_owner_arbiter.sv
// Per-pad ownership arbiter between alternate-function peripherals and GPIO.
// Every owner change tri-states the pad for TA_CYCLES cycles.
// Optional build macro PADARB_FORCE_GPIO_EN adds a config mask that forces
// selected pads away from the peripheral.
module pad_owner_arbiter
  import pad_arb_pkg::*;
#(
  parameter int N_PADS    = 8,
  parameter int TA_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_PADS-1:0] periph_req_i,
  input  logic [N_PADS-1:0] periph_out_i,
  input  logic [N_PADS-1:0] gpio_oe_i,
  input  logic [N_PADS-1:0] gpio_out_i,
  output logic [N_PADS-1:0] pad_out_o,
  output logic [N_PADS-1:0] pad_oeb_o,
  output logic [N_PADS-1:0] owner_o,
  output logic              busy_o
`ifdef PADARB_FORCE_GPIO_EN
  ,
  input  logic              cfg_we_i,
  input  logic [N_PADS-1:0] cfg_mask_i,
  output logic [N_PADS-1:0] force_mask_o
`endif
);

  logic [N_PADS-1:0] req_eff;
  logic [N_PADS-1:0] busy_bits;

`ifdef PADARB_FORCE_GPIO_EN
  logic [N_PADS-1:0] mask_q;

  // Force mask register; a set bit hides the peripheral request on that pad.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else if (cfg_we_i) begin
      mask_q <= cfg_mask_i;
    end
  end

  assign req_eff      = periph_req_i & ~mask_q;
  assign force_mask_o = mask_q;
`else
  assign req_eff = periph_req_i;
`endif

  for (genvar k = 0; k < N_PADS; k++) begin : g_pad
    pad_arb_cell #(
      .TA_CYCLES (TA_CYCLES)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req        (req_eff[k]),
      .periph_out (periph_out_i[k]),
      .gpio_oe    (gpio_oe_i[k]),
      .gpio_out   (gpio_out_i[k]),
      .pad_out    (pad_out_o[k]),
      .pad_oeb    (pad_oeb_o[k]),
      .owner      (owner_o[k]),
      .busy       (busy_bits[k])
    );
  end

  assign busy_o = |busy_bits;

endmodule

// File: tb/tb_pad_owner_arbiter.sv
// Bench for pad_owner_arbiter: behavioural per-pad model checked every cycle,
// plus directed handover scenarios with literal expectations.
module tb_pad_owner_arbiter;

  localparam int N  = 8;
  localparam int TA = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] periph_req, periph_out, gpio_oe, gpio_out;
  logic [N-1:0] pad_out, pad_oeb, owner;
  logic         busy;
`ifdef PADARB_FORCE_GPIO_EN
  logic         cfg_we;
  logic [N-1:0] cfg_mask, force_mask;
  logic [N-1:0] m_mask;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  pad_owner_arbiter #(.N_PADS(N), .TA_CYCLES(TA)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .periph_req_i (periph_req),
    .periph_out_i (periph_out),
    .gpio_oe_i    (gpio_oe),
    .gpio_out_i   (gpio_out),
    .pad_out_o    (pad_out),
    .pad_oeb_o    (pad_oeb),
    .owner_o      (owner),
    .busy_o       (busy)
`ifdef PADARB_FORCE_GPIO_EN
    ,
    .cfg_we_i     (cfg_we),
    .cfg_mask_i   (cfg_mask),
    .force_mask_o (force_mask)
`endif
  );

  always #5 clk = ~clk;

  // Model: each pad is "none" (0), "gpio" (1) or "periph" (2); a non-zero
  // turn_left means it is tri-stated in a handover for that many more cycles.
  int           m_mode[N];
  int           m_turn[N];
  logic [N-1:0] e_out, e_oeb, e_owner;
  logic         e_busy;
  logic [N-1:0] r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_mode[k] = 0;
        m_turn[k] = 0;
      end
`ifdef PADARB_FORCE_GPIO_EN
      m_mask = '0;
`endif
    end else begin
      r = periph_req;
`ifdef PADARB_FORCE_GPIO_EN
      r = periph_req & ~m_mask;
      if (cfg_we) m_mask = cfg_mask;
`endif
      for (int k = 0; k < N; k++) begin
        if (m_turn[k] > 0) begin
          if (m_turn[k] == 1) begin
            m_turn[k] = 0;
            m_mode[k] = r[k] ? 2 : (gpio_oe[k] ? 1 : 0);
          end else begin
            m_turn[k] = m_turn[k] - 1;
          end
        end else if (m_mode[k] == 0) begin
          m_mode[k] = r[k] ? 2 : (gpio_oe[k] ? 1 : 0);
        end else if (m_mode[k] == 1) begin
          if (r[k]) m_turn[k] = TA;
          else if (!gpio_oe[k]) m_mode[k] = 0;
        end else begin
          if (!r[k]) begin
            if (gpio_oe[k]) m_turn[k] = TA;
            else m_mode[k] = 0;
          end
        end
      end
    end
    e_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      e_out[k]   = 1'b0;
      e_oeb[k]   = 1'b1;
      e_owner[k] = 1'b0;
      if (m_turn[k] > 0) begin
        e_busy = 1'b1;
      end else if (m_mode[k] == 1) begin
        e_oeb[k] = ~gpio_oe[k];
        e_out[k] = gpio_out[k];
      end else if (m_mode[k] == 2) begin
        e_oeb[k]   = 1'b0;
        e_out[k]   = periph_out[k];
        e_owner[k] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model pad_out", pad_out, e_out);
      check("model pad_oeb", pad_oeb, e_oeb);
      check("model owner", owner, e_owner);
      check("model busy", {7'b0, busy}, {7'b0, e_busy});
`ifdef PADARB_FORCE_GPIO_EN
      check("model force_mask", force_mask, m_mask);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    periph_req = '0;
    periph_out = '0;
    gpio_oe    = '0;
    gpio_out   = '0;
`ifdef PADARB_FORCE_GPIO_EN
    cfg_we   = 1'b0;
    cfg_mask = '0;
`endif
    repeat (2) tick();
    chk_en = 1'b1;
    check("reset oeb", pad_oeb, 8'hFF);
    check("reset out", pad_out, 8'h00);
    check("reset owner", owner, 8'h00);
    check("reset busy", {7'b0, busy}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("idle oeb", pad_oeb, 8'hFF);

    // Pad 0: GPIO then handover to peripheral.
    gpio_oe[0] = 1'b1; gpio_out[0] = 1'b1;
    tick();
    check("p0 gpio oeb", pad_oeb, 8'hFE);
    check("p0 gpio out", pad_out, 8'h01);
    periph_req[0] = 1'b1; periph_out[0] = 1'b0;
    tick();
    check("p0 turn1 oeb", pad_oeb, 8'hFF);
    check("p0 turn1 busy", {7'b0, busy}, 8'h01);
    tick();
    check("p0 turn2 oeb", pad_oeb, 8'hFF);
    check("p0 turn2 busy", {7'b0, busy}, 8'h01);
    tick();
    check("p0 periph oeb", pad_oeb, 8'hFE);
    check("p0 periph out", pad_out, 8'h00);
    check("p0 periph owner", owner, 8'h01);
    check("p0 periph busy", {7'b0, busy}, 8'h00);
    periph_out[0] = 1'b1;
    tick();
    check("p0 data follow", pad_out, 8'h01);
    periph_req[0] = 1'b0; gpio_oe[0] = 1'b0; gpio_out[0] = 1'b0; periph_out[0] = 1'b0;
    tick();
    check("p0 release oeb", pad_oeb, 8'hFF);
    check("p0 release owner", owner, 8'h00);

    // Pad 3: simultaneous requests from IDLE go straight to the peripheral.
    periph_req[3] = 1'b1; gpio_oe[3] = 1'b1; periph_out[3] = 1'b1;
    tick();
    check("p3 owner", owner, 8'h08);
    check("p3 oeb", pad_oeb, 8'hF7);
    check("p3 out", pad_out, 8'h08);
    check("p3 no turn", {7'b0, busy}, 8'h00);
    periph_req[3] = 1'b0; gpio_oe[3] = 1'b0; periph_out[3] = 1'b0;
    tick();

    // Pad 5: request drops during the turnaround, pad lands in IDLE.
    gpio_oe[5] = 1'b1;
    tick();
    check("p5 gpio oeb", pad_oeb, 8'hDF);
    periph_req[5] = 1'b1;
    tick();
    check("p5 turn1 busy", {7'b0, busy}, 8'h01);
    periph_req[5] = 1'b0; gpio_oe[5] = 1'b0;
    tick();
    check("p5 turn2 busy", {7'b0, busy}, 8'h01);
    check("p5 turn2 oeb", pad_oeb, 8'hFF);
    tick();
    check("p5 idle busy", {7'b0, busy}, 8'h00);
    check("p5 idle oeb", pad_oeb, 8'hFF);
    check("p5 idle owner", owner, 8'h00);

    // Pad 2: asynchronous reset in the middle of a turnaround.
    gpio_oe[2] = 1'b1; gpio_out[2] = 1'b1;
    tick();
    periph_req[2] = 1'b1; periph_out[2] = 1'b1;
    tick();
    check("p2 turn busy", {7'b0, busy}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("p2 async oeb", pad_oeb, 8'hFF);
    check("p2 async out", pad_out, 8'h00);
    check("p2 async owner", owner, 8'h00);
    check("p2 async busy", {7'b0, busy}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("p2 restart owner", owner, 8'h04);
    check("p2 restart busy", {7'b0, busy}, 8'h00);
    check("p2 restart oeb", pad_oeb, 8'hFB);
    periph_req[2] = 1'b0; gpio_oe[2] = 1'b0; gpio_out[2] = 1'b0; periph_out[2] = 1'b0;
    tick();

`ifdef PADARB_FORCE_GPIO_EN
    // Pad 1: force mask pushes the peripheral off through a turnaround.
    periph_req[1] = 1'b1; gpio_oe[1] = 1'b1; gpio_out[1] = 1'b1; periph_out[1] = 1'b0;
    tick();
    check("p1 periph owner", owner, 8'h02);
    cfg_we = 1'b1; cfg_mask = 8'h02;
    tick();
    cfg_we = 1'b0;
    check("p1 mask loaded", force_mask, 8'h02);
    check("p1 still periph", owner, 8'h02);
    tick();
    check("p1 turn1 busy", {7'b0, busy}, 8'h01);
    tick();
    check("p1 turn2 busy", {7'b0, busy}, 8'h01);
    tick();
    check("p1 gpio owner", owner, 8'h00);
    check("p1 gpio oeb", pad_oeb, 8'hFD);
    check("p1 gpio out", pad_out, 8'h02);
    tick();
    check("p1 req ignored", owner, 8'h00);
    cfg_we = 1'b1; cfg_mask = 8'h00;
    periph_req[1] = 1'b0; gpio_oe[1] = 1'b0; gpio_out[1] = 1'b0;
    tick();
    cfg_we = 1'b0;
    tick();
`endif

    // Mixed traffic on all pads, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) periph_req = N'($urandom);
      if ($urandom_range(0, 3) == 0) gpio_oe = N'($urandom);
      periph_out = N'($urandom);
      gpio_out   = N'($urandom);
`ifdef PADARB_FORCE_GPIO_EN
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_mask = N'($urandom);
`endif
      tick();
    end
    periph_req = '0; gpio_oe = '0;
`ifdef PADARB_FORCE_GPIO_EN
    cfg_we = 1'b0;
`endif
    repeat (TA + 3) tick();
    check("final oeb", pad_oeb, 8'hFF);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
